// File: rtl/serial_tx_arbiter.sv
// serial_tx_arbiter: round-robin arbiter in front of one LSB-first
// parallel-to-serial shift engine shared by NUM_REQ requesters.
// Optional feature macro: SERIAL_PARITY_EN appends an even-parity bit to
// every frame (FRAME_LEN = WIDTH+1); undefined gives FRAME_LEN = WIDTH.
module serial_tx_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         req_valid_i,
  input  logic [NUM_REQ*WIDTH-1:0]   req_data_i,
  output logic [NUM_REQ-1:0]         req_ready_o,
  output logic                       serial_o,
  output logic                       valid_o,
  output logic [$clog2(NUM_REQ)-1:0] gnt_id_o,
  output logic                       busy_o
);

`ifdef SERIAL_PARITY_EN
  localparam int FRAME_LEN = WIDTH + 1;
`else
  localparam int FRAME_LEN = WIDTH;
`endif
  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = $clog2(FRAME_LEN);
  localparam logic [CW-1:0] LAST_BIT = CW'(FRAME_LEN - 1);
  localparam logic [IW-1:0] LAST_REQ = IW'(NUM_REQ - 1);

  typedef enum logic {S_IDLE, S_SHIFT} state_t;

  state_t               r_state;
  logic [FRAME_LEN-1:0] r_shift;   // bits still to send after the one on serial_o
  logic [CW-1:0]        r_cnt;     // index of the bit currently on serial_o
  logic [IW-1:0]        r_ptr;     // round-robin search start
  logic                 r_serial;
  logic                 r_valid;
  logic                 r_busy;
  logic [IW-1:0]        r_gnt;

  logic                 w_window;
  logic                 w_found;
  logic                 w_xfer;
  logic [IW-1:0]        w_gnt;
  logic [IW-1:0]        w_ptr_next;
  logic [WIDTH-1:0]     w_word;
  logic [FRAME_LEN-1:0] w_frame;

  // A new word may be accepted while idle or during the final bit of a frame.
  assign w_window = (r_state == S_IDLE) || (r_cnt == LAST_BIT);

  // Round-robin pick: first valid at or above r_ptr, else first valid below it.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no
    // path leaves it unassigned and no latch is inferred.
    w_found = 1'b0;
    w_gnt   = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      if (!w_found && req_valid_i[j] && (IW'(j) >= r_ptr)) begin
        w_found = 1'b1;
        w_gnt   = IW'(j);
      end
    end
    for (int j = 0; j < NUM_REQ; j++) begin
      if (!w_found && req_valid_i[j]) begin
        w_found = 1'b1;
        w_gnt   = IW'(j);
      end
    end
  end

  // Select the granted requester's word.
  always_comb begin
    w_word = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      if (IW'(j) == w_gnt) w_word = req_data_i[j*WIDTH +: WIDTH];
    end
  end

`ifdef SERIAL_PARITY_EN
  assign w_frame = {^w_word, w_word};
`else
  assign w_frame = w_word;
`endif

  assign w_xfer     = !reset && w_window && w_found;
  assign w_ptr_next = (w_gnt == LAST_REQ) ? '0 : w_gnt + 1'b1;

  // One-hot accept toward the granted requester, only inside an accept window.
  always_comb begin
    req_ready_o = '0;
    if (w_xfer) req_ready_o[w_gnt] = 1'b1;
  end

  // FSM, shift engine, arbitration pointer and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: non-blocking assignments so every register here samples the
    // pre-edge values of the others, independent of statement order.
    if (reset) begin
      r_state  <= S_IDLE;
      r_shift  <= '0;
      r_cnt    <= '0;
      r_ptr    <= '0;
      r_serial <= 1'b0;
      r_valid  <= 1'b0;
      r_busy   <= 1'b0;
      r_gnt    <= '0;
    end else if (w_xfer) begin
      r_state  <= S_SHIFT;
      r_serial <= w_frame[0];
      r_shift  <= w_frame >> 1;
      r_cnt    <= '0;
      r_valid  <= 1'b1;
      r_busy   <= 1'b1;
      r_gnt    <= w_gnt;
      r_ptr    <= w_ptr_next;
    end else if (r_state == S_SHIFT) begin
      if (r_cnt == LAST_BIT) begin
        r_state  <= S_IDLE;
        r_serial <= 1'b0;
        r_valid  <= 1'b0;
        r_busy   <= 1'b0;
        r_cnt    <= '0;
      end else begin
        r_serial <= r_shift[0];
        r_shift  <= r_shift >> 1;
        r_cnt    <= r_cnt + 1'b1;
      end
    end
  end

  assign serial_o = r_serial;
  assign valid_o  = r_valid;
  assign busy_o   = r_busy;
  assign gnt_id_o = r_gnt;

endmodule
